// File: rtl/xs3_pkg.sv
// -----------------------------------------------------------------------------
// xs3_pkg
// Shared definitions for the excess-3 digit-serial adder.
//   XS3_BIAS          : excess-3 offset (3)
//   XS3_ONE           : excess-3 code for decimal 1 (the overflow carry digit)
//   XS3_MIN / XS3_MAX : legal excess-3 code range (decimal 0..9)
//   xs3_state_e       : FSM state encodings ST_RUN / ST_CARRY
//   xs3_code_illegal  : flags a 4-bit code outside the legal excess-3 range
// Optional feature macro used by the importing files: XS3_CHECK_EN.
// -----------------------------------------------------------------------------
package xs3_pkg;

    localparam logic [3:0] XS3_BIAS = 4'd3;
    localparam logic [3:0] XS3_ONE  = 4'b0100;
    localparam logic [3:0] XS3_MIN  = 4'b0011;
    localparam logic [3:0] XS3_MAX  = 4'b1100;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CARRY = 1'b1
    } xs3_state_e;

    // True when the code does not represent a decimal digit in excess-3.
    function automatic logic xs3_code_illegal(input logic [3:0] code);
        return (code < XS3_MIN) || (code > XS3_MAX);
    endfunction

endpackage

// File: rtl/xs3_digit_add.sv
// -----------------------------------------------------------------------------
// xs3_digit_add
// Combinational one-digit excess-3 adder.
//   a, b  : operand digits, excess-3
//   cin   : decimal carry in from the previous (less significant) digit
//   sum   : sum digit, excess-3
//   cout  : decimal carry out
//   err   : (only with XS3_CHECK_EN) an operand code is illegal
// Optional feature macro: XS3_CHECK_EN adds the err output and checking logic.
// -----------------------------------------------------------------------------
module xs3_digit_add
    import xs3_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
`ifdef XS3_CHECK_EN
    ,
    output logic       err
`endif
);

    logic [4:0] raw_s;

    // Two excess-3 codes carry a combined bias of 6, so the 5-bit raw sum
    // overflows exactly when the decimal sum reaches 10.
    assign raw_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

    // Re-bias the raw sum: add 3 after a decimal carry, remove 3 otherwise.
    always_comb begin
        sum  = 4'b0000;
        cout = 1'b0;
        if (raw_s[4]) begin
            sum  = raw_s[3:0] + XS3_BIAS;
            cout = 1'b1;
        end else begin
            sum  = raw_s[3:0] - XS3_BIAS;
            cout = 1'b0;
        end
    end

`ifdef XS3_CHECK_EN
    // Flag either operand that is not a legal excess-3 digit.
    always_comb begin
        err = xs3_code_illegal(a) || xs3_code_illegal(b);
    end
`endif

endmodule

// File: rtl/xs3_serial_adder.sv
// -----------------------------------------------------------------------------
// xs3_serial_adder
// Digit-serial excess-3 adder, least-significant digit first, with valid/ready
// handshakes on both sides. Keeps the decimal carry between digits and appends
// an extra excess-3 "1" digit when the final digit overflows.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : input handshake (in_ready depends on out_ready)
//   a_xs3, b_xs3      : operand digits, excess-3
//   in_last           : current pair is the most-significant digit
//   out_valid/out_ready : output handshake
//   sum_xs3           : registered sum digit, excess-3
//   out_last          : registered flag, final digit of this sum
//   out_err           : registered flag, illegal input code (XS3_CHECK_EN only)
// Optional feature macro: XS3_CHECK_EN enables input-code checking; without it
// out_err stays 0.
// -----------------------------------------------------------------------------
module xs3_serial_adder
    import xs3_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a_xs3,
    input  logic [3:0] b_xs3,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] sum_xs3,
    output logic       out_last,
    output logic       out_err
);

    xs3_state_e state_r;
    xs3_state_e state_next_s;

    logic       carry_r;
    logic       out_valid_r;
    logic [3:0] sum_r;
    logic       last_r;
    logic       err_r;

    logic [3:0] sum_s;
    logic       cout_s;
    logic       err_s;

    logic       slot_free_s;
    logic       in_ready_s;
    logic       load_digit_s;
    logic       load_carry_s;

    xs3_digit_add u_digit_add (
        .a    (a_xs3),
        .b    (b_xs3),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (cout_s)
`ifdef XS3_CHECK_EN
        ,
        .err  (err_s)
`endif
    );

`ifndef XS3_CHECK_EN
    assign err_s = 1'b0;
`endif

    // The output slot can take a new digit when empty or being drained now.
    assign slot_free_s = !out_valid_r || out_ready;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic: an overflowing last digit detours through CARRY.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (load_digit_s && in_last && cout_s) begin
                    state_next_s = ST_CARRY;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_CARRY: begin
                if (load_carry_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_CARRY;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // FSM outputs: input handshake and output-register load strobes.
    always_comb begin
        in_ready_s   = 1'b0;
        load_digit_s = 1'b0;
        load_carry_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                in_ready_s   = slot_free_s;
                load_digit_s = in_valid && slot_free_s;
            end
            ST_CARRY: begin
                load_carry_s = slot_free_s;
            end
            default: begin
                in_ready_s   = 1'b0;
                load_digit_s = 1'b0;
                load_carry_s = 1'b0;
            end
        endcase
    end

    // Decimal carry between digits; a last digit without overflow leaves
    // cout_s at 0, and the CARRY digit clears it, so each sum starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_r <= 1'b0;
        end else if (load_digit_s) begin
            carry_r <= cout_s;
        end else if (load_carry_s) begin
            carry_r <= 1'b0;
        end else begin
            carry_r <= carry_r;
        end
    end

    // Output register: load a sum digit or the carry digit, hold while
    // stalled, and go empty after a handshake with nothing new to load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            sum_r       <= 4'b0000;
            last_r      <= 1'b0;
            err_r       <= 1'b0;
        end else if (load_digit_s) begin
            out_valid_r <= 1'b1;
            sum_r       <= sum_s;
            last_r      <= in_last && !cout_s;
            err_r       <= err_s;
        end else if (load_carry_s) begin
            out_valid_r <= 1'b1;
            sum_r       <= XS3_ONE;
            last_r      <= 1'b1;
            err_r       <= 1'b0;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            sum_r       <= sum_r;
            last_r      <= last_r;
            err_r       <= err_r;
        end else begin
            out_valid_r <= out_valid_r;
            sum_r       <= sum_r;
            last_r      <= last_r;
            err_r       <= err_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign sum_xs3   = sum_r;
    assign out_last  = last_r;
    assign out_err   = err_r;

endmodule
